spi_burst_seq: RTL



---
 rtl/spi_burst_seq_pkg.sv | 9 +
 rtl/spi_burst_seq_delay.sv | 18 +
 rtl/spi_burst_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spi_burst_seq_pkg.sv
// spi_burst_seq_pkg: FSM states, delay counter width and timing defaults for the burst sequencer
package spi_burst_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_EXCH, S_WAIT, S_GAP, S_HOLD} state_t;
  localparam int DLY_W        = 16;
  localparam int DEF_CS_SETUP = 4;
  localparam int DEF_CS_HOLD  = 4;
  localparam int DEF_GAP      = 2;
  localparam int DEF_TIMEOUT  = 1024;
endpackage

// File: rtl/spi_burst_seq_delay.sv
// spi_burst_seq_delay: loadable down-counter; expired is high during the last counted cycle
module spi_burst_seq_delay #(
  parameter int W = 16
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);
  logic [W-1:0] cnt;
  // reload on start, otherwise count down and park at zero
  always_ff @(posedge iclk)
    if (irst) cnt <= '0;
    else if (start) cnt <= load;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expired = cnt == W'(1);
endmodule

// File: rtl/spi_burst_seq.sv
// spi_burst_seq: multi-byte burst sequencer in front of spi_ctrl; define SPI_BURST_TIMEOUT_EN for the WAIT watchdog and err output
module spi_burst_seq
  import spi_burst_seq_pkg::*;
#(
  parameter int BYTE     = 8,
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int GAP      = DEF_GAP,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_msb_first,
  input  logic             cmd_keep_cs,
  input  logic [BYTE-1:0]  tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [BYTE-1:0]  rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             busy,
`ifdef SPI_BURST_TIMEOUT_EN
  output logic             err,
`endif
  output logic             spi_select,
  output logic             spi_msb_lsb_sel,
  output logic             spi_exchange,
  output logic [BYTE-1:0]  spi_send_data,
  input  logic             spi_busy,
  input  logic             spi_ready,
  input  logic [BYTE-1:0]  spi_recv_data
);
`ifdef SPI_BURST_TIMEOUT_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  state_t state, nxt;
  logic [LEN_W-1:0] rem;
  logic msb, keep, cs_held, accept, consume, hit, last, tmo, start, expired;
  logic [DLY_W-1:0] load;
  spi_burst_seq_delay #(.W(DLY_W)) u_dly (
    .iclk    (iclk),
    .irst    (irst),
    .start   (start),
    .load    (load),
    .expired (expired)
  );
  // state register
  always_ff @(posedge iclk) state <= irst ? S_IDLE : nxt;
  // next state, handshake strobes and delay reload on entry to a timed state
  always_comb begin
    accept  = state == S_IDLE && cmd_valid && cmd_ready;
    consume = state == S_LOAD && tx_valid;
    hit     = state == S_WAIT && spi_ready;
    last    = rem == '0;
    tmo     = WDOG && state == S_WAIT && !spi_ready && expired;
    nxt     = state;
    unique case (state)
      S_IDLE:  nxt = accept ? (cs_held ? S_LOAD : S_SETUP) : S_IDLE;
      S_SETUP: nxt = expired ? S_LOAD : S_SETUP;
      S_LOAD:  nxt = consume ? S_EXCH : S_LOAD;
      S_EXCH:  nxt = S_WAIT;
      S_WAIT:  nxt = hit ? (!last ? (GAP == 0 ? S_LOAD : S_GAP) : keep ? S_IDLE : S_HOLD) : tmo ? S_HOLD : S_WAIT;
      S_GAP:   nxt = expired ? S_LOAD : S_GAP;
      S_HOLD:  nxt = expired ? S_IDLE : S_HOLD;
      default: nxt = S_IDLE;
    endcase
    start = nxt != state && (nxt == S_SETUP || nxt == S_GAP || nxt == S_HOLD || (WDOG && nxt == S_WAIT));
    load  = nxt == S_SETUP ? DLY_W'(CS_SETUP) : nxt == S_GAP ? DLY_W'(GAP) : nxt == S_HOLD ? DLY_W'(CS_HOLD) : DLY_W'(TIMEOUT);
  end
  // registered outputs, burst context and chip-select ownership
  always_ff @(posedge iclk)
    if (irst) begin
      cmd_ready       <= 1'b0;
      tx_ready        <= 1'b0;
      busy            <= 1'b0;
      spi_exchange    <= 1'b0;
      rx_valid        <= 1'b0;
      done            <= 1'b0;
      rx_data         <= '0;
      spi_send_data   <= '0;
      spi_msb_lsb_sel <= 1'b1;
      spi_select      <= 1'b1;
      cs_held         <= 1'b0;
      rem             <= '0;
      msb             <= 1'b1;
      keep            <= 1'b0;
    end else begin
      cmd_ready    <= nxt == S_IDLE && !spi_busy;
      tx_ready     <= nxt == S_LOAD;
      busy         <= nxt != S_IDLE;
      spi_exchange <= state == S_EXCH;
      rx_valid     <= hit;
      done         <= (hit && last && keep) || (state == S_HOLD && expired);
      if (accept) begin
        rem        <= cmd_len;
        msb        <= cmd_msb_first;
        keep       <= cmd_keep_cs;
        spi_select <= 1'b0;
      end
      if (consume) begin
        spi_send_data   <= tx_data;
        spi_msb_lsb_sel <= msb;
      end
      if (hit) rx_data <= spi_recv_data;
      if (hit && !last) rem <= rem - LEN_W'(1);
      if (hit && last && keep) cs_held <= 1'b1;
      if (state == S_HOLD && expired) begin
        spi_select <= 1'b1;
        cs_held    <= 1'b0;
      end
    end
`ifdef SPI_BURST_TIMEOUT_EN
  // sticky watchdog flag, cleared by the next accepted command
  always_ff @(posedge iclk) err <= irst ? 1'b0 : tmo ? 1'b1 : accept ? 1'b0 : err;
`endif
endmodule
